// File: rtl/zone_picker.sv
// zone_picker
//
// Snapshots the 21-entry random-number history on a start pulse. It then
// scans the snapshot from entry 0 to entry 20 and rejects every value that
// is not a legal court zone (v >= ZONES). At most NEED accepted zones are
// offered, one at a time, over a valid/ready handshake.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   random_numbers  21 x 3-bit history, entry 0 newest
//   start           batch request, honoured only while idle
//   zone            zone index on offer
//   zone_valid      zone is on offer
//   zone_ready      consumer accepts zone (transfer when valid && ready)
//   busy            batch in progress
//   done            one-cycle pulse at batch end
//   issued_count    zones transferred in the current or last batch
//   skip_count      entries rejected in the current or last batch
module zone_picker #(
  parameter int ZONES = 5,
  parameter int NEED  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] random_numbers [21],
  input  logic       start,
  output logic [2:0] zone,
  output logic       zone_valid,
  input  logic       zone_ready,
  output logic       busy,
  output logic       done,
  output logic [4:0] issued_count,
  output logic [4:0] skip_count
);

  localparam logic [3:0] ZONE_LIM = 4'(ZONES);
  localparam logic [4:0] NEED_LIM = 5'(NEED);
  localparam logic [4:0] LAST_IDX = 5'd20;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t     state, state_d;
  logic [2:0] snap   [21];
  logic [2:0] snap_d [21];
  logic [4:0] idx, idx_d;
  logic [2:0] zone_d;
  logic       zone_valid_d, busy_d, done_d;
  logic [4:0] issued_d, skip_d;

  logic [2:0] cur;
  logic       accept;
  logic       at_last;
  logic [4:0] issued_inc;

  assign cur        = snap[idx];
  assign accept     = {1'b0, cur} < ZONE_LIM;
  assign at_last    = (idx == LAST_IDX);
  assign issued_inc = issued_count + 5'd1;

  // NOTE: every signal this block writes gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    snap_d       = snap;
    idx_d        = idx;
    zone_d       = zone;
    zone_valid_d = zone_valid;
    busy_d       = busy;
    done_d       = 1'b0;
    issued_d     = issued_count;
    skip_d       = skip_count;

    unique case (state)
      IDLE: begin
        if (start) begin
          snap_d   = random_numbers;
          idx_d    = '0;
          issued_d = '0;
          skip_d   = '0;
          busy_d   = 1'b1;
          state_d  = SCAN;
        end
      end

      SCAN: begin
        if (accept) begin
          zone_d       = cur;
          zone_valid_d = 1'b1;
          state_d      = HOLD;
        end else begin
          skip_d = skip_count + 5'd1;
          if (at_last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx + 5'd1;
          end
        end
      end

      HOLD: begin
        // zone/zone_valid stay frozen until the consumer takes the value.
        if (zone_ready) begin
          zone_valid_d = 1'b0;
          issued_d     = issued_inc;
          if (issued_inc == NEED_LIM || at_last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx + 5'd1;
            state_d = SCAN;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      // NOTE: the snapshot is reset as well so a batch can never read
      // undefined history; it is small enough to live in flops.
      snap         <= '{default: '0};
      idx          <= '0;
      zone         <= '0;
      zone_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
      skip_count   <= '0;
    end else begin
      state        <= state_d;
      snap         <= snap_d;
      idx          <= idx_d;
      zone         <= zone_d;
      zone_valid   <= zone_valid_d;
      busy         <= busy_d;
      done         <= done_d;
      issued_count <= issued_d;
      skip_count   <= skip_d;
    end
  end

endmodule
